alu_req_master: RTL and testbench
=================================

Name: alu_req_master

Overview:
Requester/initiator side of the add/sub engine interface. It accepts host commands (operands plus op) on a valid/ready port and drives one en-pulsed transaction to the arithmetic responder. It waits for the responder's result, checks it against a locally computed reference, and returns result and status on a valid/ready response port. It sits between the host bus glue and the add/sub responder in the same clock domain.

Parameters:
DW, 8, operand/result width in bits
TIMEOUT, 15, max WAIT cycles before abort (used only with the optional feature); must be >= 1
CNT_W, 16, width of the transaction counter

Ports:
sys_clk  input  1  system clock, rising edge
sys_rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  block can accept a command
cmd_op  input  1  0 = add, 1 = subtract
cmd_a  input  DW  operand a
cmd_b  input  DW  operand b
alu_en  output  1  single-cycle start pulse to responder
alu_op  output  1  op presented to responder
alu_a  output  DW  operand a to responder
alu_b  output  DW  operand b to responder
alu_s  input  DW  responder result
alu_done  input  1  responder result valid, one-cycle pulse
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_data  output  DW  captured alu_s
rsp_mismatch  output  1  alu_s differs from the local reference
rsp_err  output  1  transaction aborted by timeout
txn_count  output  CNT_W  completed response handshakes

Behaviour:
- Reset: asynchronous on sys_rst_n low. State = IDLE. Every output is 0, including cmd_ready, alu_*, rsp_*, and txn_count. Internal registers are 0. Reset asserted mid-transaction drops the transaction with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1; it is 0 in every other state.
  - On cmd_valid & cmd_ready, register op/a/b.
  - Compute exp = (op ? a - b : a + b) mod 2^DW and register it.
  - Go to ISSUE.
- ISSUE:
  - Exactly one cycle. alu_en = 1.
  - alu_op/alu_a/alu_b = registered values, held stable from ISSUE through WAIT.
  - alu_done in this cycle is ignored.
  - Go to WAIT.
- WAIT:
  - alu_en = 0.
  - On alu_done = 1: capture rsp_data = alu_s, rsp_mismatch = (alu_s != exp), rsp_err = 0. Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_mismatch and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: txn_count += 1, wrapping from 2^CNT_W-1 to 0. Go to IDLE.
  - The next command can be accepted in the cycle after the handshake.
- Latency: command accepted at cycle T.
  - alu_en high at T+1.
  - If alu_done arrives at cycle T+1+k (k >= 1), rsp_valid rises at T+2+k.
  - Minimum command-to-response is 3 cycles.
- alu_done outside WAIT (IDLE, ISSUE, RESP) is ignored and does not alter state or outputs.
- alu_a/alu_b/alu_op return to 0 in IDLE.
- Arithmetic is unsigned modulo 2^DW. Borrow and carry are discarded.

Optional Feature:
ALU_REQ_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without alu_done.
  - When it reaches TIMEOUT with no alu_done, go to RESP with rsp_err = 1, rsp_data = 0, rsp_mismatch = 0.
  - alu_done in the same cycle the counter reaches TIMEOUT wins: normal response, rsp_err = 0.
- Undefined:
  - No counter. WAIT holds indefinitely until alu_done.
  - rsp_err is tied to 0.

Test Plan:
- Add: cmd op=0 a=5 b=2, responder returns s=7 two cycles after alu_en -> alu_en high exactly 1 cycle at T+1; rsp_valid with rsp_data=7, rsp_mismatch=0; txn_count=1 after handshake.
- Subtract with wrap: op=1 a=2 b=5 (DW=8), responder returns 253 -> rsp_data=253, rsp_mismatch=0. Then add a=255 b=1, responder returns 0 -> rsp_mismatch=0.
- Faulty responder: op=0 a=5 b=2, responder returns 3 -> rsp_data=3, rsp_mismatch=1, rsp_err=0.
- Backpressure and spurious done:
  - Hold rsp_ready=0 for 4 cycles -> rsp_* stable and cmd_ready=0 throughout.
  - A spurious alu_done pulse in IDLE -> no state change, txn_count unchanged.
- Timeout (macro defined, TIMEOUT=15): responder never asserts done -> rsp_valid 15 WAIT cycles later with rsp_err=1, rsp_data=0. With the macro undefined, the block stays in WAIT and rsp_valid stays 0 for at least 100 cycles.
- Reset mid-WAIT: drive sys_rst_n low asynchronously between clock edges -> all outputs 0 immediately. After release, cmd_ready=1, txn_count=0, and a new add a=1 b=1 returns rsp_data=2.

Source files
------------

// File: rtl/alu_req_master_if.sv
// ----------------------------------------------------------------------------
// alu_req_master_if
// Bundles the three channels around the add/sub requester:
//   cmd_* : host command channel (valid/ready), operands plus op
//   alu_* : en-pulsed request to the arithmetic responder and its result
//   rsp_* : response channel back to the host (valid/ready)
// Modports:
//   master : the requester block (alu_req_master)
//   slave  : the environment around it (host glue plus responder)
// ----------------------------------------------------------------------------
interface alu_req_master_if #(
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;

    logic          alu_en;
    logic          alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_s;
    logic          alu_done;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_mismatch;
    logic          rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_s, alu_done,
        input  rsp_ready,
        output cmd_ready,
        output alu_en, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_data, rsp_mismatch, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_s, alu_done,
        output rsp_ready,
        input  cmd_ready,
        input  alu_en, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_data, rsp_mismatch, rsp_err
    );
endinterface

// File: rtl/alu_req_master.sv
// ----------------------------------------------------------------------------
// alu_req_master
// Requester side of the add/sub engine. Accepts one host command, issues a
// single alu_en pulse to the responder, waits for alu_done, compares the
// returned sum/difference with a locally computed reference and presents
// result plus status on the response channel.
//
// Ports:
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   bus        : alu_req_master_if.master (cmd_*, alu_*, rsp_* channels)
//   txn_count  : number of completed response handshakes (wraps)
//
// Build option:
//   ALU_REQ_TIMEOUT_EN : when defined, WAIT is aborted after TIMEOUT cycles
//                        without alu_done and the response carries rsp_err=1.
//                        When undefined, WAIT holds until alu_done and
//                        rsp_err is tied low.
//
// All outputs come straight from flops so that every output is 0 while in
// reset, including cmd_ready (it rises on the first clock after release).
// ----------------------------------------------------------------------------
module alu_req_master #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    alu_req_master_if.master bus,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Elaboration guard: a zero timeout would abort before any WAIT cycle.
    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("alu_req_master: TIMEOUT must be >= 1");
    end

    // Reference result, unsigned modulo 2^DW (carry/borrow dropped).
    function automatic logic [DW-1:0] ref_result(input logic op,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        logic [DW-1:0] r;
        if (op) begin
            r = a - b;
        end else begin
            r = a + b;
        end
        return r;
    endfunction

    state_t            state_r,        state_nxt_s;
    logic              cmd_ready_r,    cmd_ready_nxt_s;
    logic              alu_en_r,       alu_en_nxt_s;
    logic              alu_op_r,       alu_op_nxt_s;
    logic [DW-1:0]     alu_a_r,        alu_a_nxt_s;
    logic [DW-1:0]     alu_b_r,        alu_b_nxt_s;
    logic [DW-1:0]     exp_r,          exp_nxt_s;
    logic              rsp_valid_r,    rsp_valid_nxt_s;
    logic [DW-1:0]     rsp_data_r,     rsp_data_nxt_s;
    logic              rsp_mismatch_r, rsp_mismatch_nxt_s;
    logic [CNT_W-1:0]  txn_count_r,    txn_count_nxt_s;
`ifdef ALU_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic              rsp_err_r,      rsp_err_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r,     wait_cnt_nxt_s;
`endif

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_nxt_s        = state_r;
        alu_en_nxt_s       = 1'b0;
        alu_op_nxt_s       = alu_op_r;
        alu_a_nxt_s        = alu_a_r;
        alu_b_nxt_s        = alu_b_r;
        exp_nxt_s          = exp_r;
        rsp_data_nxt_s     = rsp_data_r;
        rsp_mismatch_nxt_s = rsp_mismatch_r;
        txn_count_nxt_s    = txn_count_r;
`ifdef ALU_REQ_TIMEOUT_EN
        rsp_err_nxt_s      = rsp_err_r;
        wait_cnt_nxt_s     = wait_cnt_r;
`endif

        case (state_r)
            ST_IDLE: begin
                // cmd_ready_r is only high in IDLE, so it gates acceptance.
                if (bus.cmd_valid && cmd_ready_r) begin
                    state_nxt_s  = ST_ISSUE;
                    alu_en_nxt_s = 1'b1;
                    alu_op_nxt_s = bus.cmd_op;
                    alu_a_nxt_s  = bus.cmd_a;
                    alu_b_nxt_s  = bus.cmd_b;
                    exp_nxt_s    = ref_result(bus.cmd_op, bus.cmd_a, bus.cmd_b);
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // alu_done here is ignored; the responder cannot have seen en yet.
                state_nxt_s = ST_WAIT;
`ifdef ALU_REQ_TIMEOUT_EN
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
`endif
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
                    state_nxt_s        = ST_RESP;
                    rsp_data_nxt_s     = bus.alu_s;
                    rsp_mismatch_nxt_s = (bus.alu_s != exp_r);
`ifdef ALU_REQ_TIMEOUT_EN
                    rsp_err_nxt_s      = 1'b0;
`endif
                end else begin
`ifdef ALU_REQ_TIMEOUT_EN
                    // Counter reaches TIMEOUT on this cycle: abort.
                    if (wait_cnt_r == WAIT_W'(TIMEOUT - 1)) begin
                        state_nxt_s        = ST_RESP;
                        rsp_data_nxt_s     = {DW{1'b0}};
                        rsp_mismatch_nxt_s = 1'b0;
                        rsp_err_nxt_s      = 1'b1;
                    end else begin
                        wait_cnt_nxt_s     = wait_cnt_r + WAIT_W'(1);
                    end
`else
                    state_nxt_s = ST_WAIT;
`endif
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s        = ST_IDLE;
                    txn_count_nxt_s    = txn_count_r + CNT_W'(1);
                    alu_op_nxt_s       = 1'b0;
                    alu_a_nxt_s        = {DW{1'b0}};
                    alu_b_nxt_s        = {DW{1'b0}};
                    rsp_data_nxt_s     = {DW{1'b0}};
                    rsp_mismatch_nxt_s = 1'b0;
`ifdef ALU_REQ_TIMEOUT_EN
                    rsp_err_nxt_s      = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r        <= ST_IDLE;
            cmd_ready_r    <= 1'b0;
            alu_en_r       <= 1'b0;
            alu_op_r       <= 1'b0;
            alu_a_r        <= {DW{1'b0}};
            alu_b_r        <= {DW{1'b0}};
            exp_r          <= {DW{1'b0}};
            rsp_valid_r    <= 1'b0;
            rsp_data_r     <= {DW{1'b0}};
            rsp_mismatch_r <= 1'b0;
            txn_count_r    <= {CNT_W{1'b0}};
`ifdef ALU_REQ_TIMEOUT_EN
            rsp_err_r      <= 1'b0;
            wait_cnt_r     <= {WAIT_W{1'b0}};
`endif
        end else begin
            state_r        <= state_nxt_s;
            cmd_ready_r    <= cmd_ready_nxt_s;
            alu_en_r       <= alu_en_nxt_s;
            alu_op_r       <= alu_op_nxt_s;
            alu_a_r        <= alu_a_nxt_s;
            alu_b_r        <= alu_b_nxt_s;
            exp_r          <= exp_nxt_s;
            rsp_valid_r    <= rsp_valid_nxt_s;
            rsp_data_r     <= rsp_data_nxt_s;
            rsp_mismatch_r <= rsp_mismatch_nxt_s;
            txn_count_r    <= txn_count_nxt_s;
`ifdef ALU_REQ_TIMEOUT_EN
            rsp_err_r      <= rsp_err_nxt_s;
            wait_cnt_r     <= wait_cnt_nxt_s;
`endif
        end
    end

    assign bus.cmd_ready    = cmd_ready_r;
    assign bus.alu_en       = alu_en_r;
    assign bus.alu_op       = alu_op_r;
    assign bus.alu_a        = alu_a_r;
    assign bus.alu_b        = alu_b_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_data     = rsp_data_r;
    assign bus.rsp_mismatch = rsp_mismatch_r;
`ifdef ALU_REQ_TIMEOUT_EN
    assign bus.rsp_err      = rsp_err_r;
`else
    assign bus.rsp_err      = 1'b0;
`endif
    assign txn_count        = txn_count_r;

endmodule

// File: tb/tb_alu_req_master.sv
// ----------------------------------------------------------------------------
// tb_alu_req_master
// Directed bench for alu_req_master (DW=8, TIMEOUT=15, CNT_W=16). Inputs are
// driven on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_alu_req_master;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [15:0] txn_count;
    int          checks;
    int          errors;

    alu_req_master_if #(.DW(8)) bus ();

    alu_req_master #(.DW(8), .TIMEOUT(15), .CNT_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .txn_count (txn_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, bus.cmd_ready, 1'b0);
        chk(tag, bus.alu_en, 1'b0);
        chk(tag, bus.alu_op, 1'b0);
        chk(tag, bus.alu_a, 8'h00);
        chk(tag, bus.alu_b, 8'h00);
        chk(tag, bus.rsp_valid, 1'b0);
        chk(tag, bus.rsp_data, 8'h00);
        chk(tag, bus.rsp_mismatch, 1'b0);
        chk(tag, bus.rsp_err, 1'b0);
        chk(tag, txn_count, 16'h0000);
    endtask

    // One full transaction, called right after a falling edge with the DUT
    // idle. The responder answers k cycles after the alu_en cycle.
    task automatic run_txn(input logic op, input logic [7:0] a, input logic [7:0] b,
                           input int k, input logic [7:0] s, input logic mm,
                           input int hold, input logic [15:0] cnt);
        chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        chk("alu_en_issue", bus.alu_en, 1'b1);
        chk("alu_op_issue", bus.alu_op, op);
        chk("alu_a_issue", bus.alu_a, a);
        chk("alu_b_issue", bus.alu_b, b);
        chk("cmd_ready_issue", bus.cmd_ready, 1'b0);
        for (int i = 1; i <= k; i++) begin
            @(negedge sys_clk);
            checks++;
            if (bus.alu_en !== 1'b0) begin
                errors++;
                $error("FAIL alu_en_wait: observed %0h expected %0h", bus.alu_en, 1'b0);
            end
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $error("FAIL rsp_valid_wait: observed %0h expected %0h", bus.rsp_valid, 1'b0);
            end
            checks++;
            if (bus.alu_a !== a) begin
                errors++;
                $error("FAIL alu_a_wait: observed %0h expected %0h", bus.alu_a, a);
            end
            if (i == k) begin
                bus.alu_done = 1'b1;
                bus.alu_s    = s;
            end
        end
        @(negedge sys_clk);
        bus.alu_done = 1'b0;
        bus.alu_s    = 8'h00;
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_data", bus.rsp_data, s);
        chk("rsp_mismatch", bus.rsp_mismatch, mm);
        chk("rsp_err", bus.rsp_err, 1'b0);
        chk("cmd_ready_resp", bus.cmd_ready, 1'b0);
        for (int h = 1; h <= hold; h++) begin
            @(negedge sys_clk);
            bus.alu_done = 1'b0;
            checks++;
            if (bus.rsp_valid !== 1'b1) begin
                errors++;
                $error("FAIL bp_rsp_valid: observed %0h expected %0h", bus.rsp_valid, 1'b1);
            end
            checks++;
            if (bus.rsp_data !== s) begin
                errors++;
                $error("FAIL bp_rsp_data: observed %0h expected %0h", bus.rsp_data, s);
            end
            checks++;
            if (bus.rsp_mismatch !== mm) begin
                errors++;
                $error("FAIL bp_rsp_mismatch: observed %0h expected %0h", bus.rsp_mismatch, mm);
            end
            checks++;
            if (bus.cmd_ready !== 1'b0) begin
                errors++;
                $error("FAIL bp_cmd_ready: observed %0h expected %0h", bus.cmd_ready, 1'b0);
            end
            if (h == 2 && hold > 2) begin
                bus.alu_done = 1'b1;
                bus.alu_s    = ~s;
            end
        end
        bus.alu_done  = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge sys_clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", bus.rsp_valid, 1'b0);
        chk("cmd_ready_after_hs", bus.cmd_ready, 1'b1);
        chk("txn_count", txn_count, cnt);
        chk("alu_a_idle", bus.alu_a, 8'h00);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        sys_rst_n     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.alu_s     = 8'h00;
        bus.alu_done  = 1'b0;
        bus.rsp_ready = 1'b0;

        #12;
        check_all_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $error("FAIL cmd_ready_after_reset: observed %0h expected %0h", bus.cmd_ready, 1'b1);
        end

        run_txn(1'b0, 8'd5, 8'd2, 2, 8'd7, 1'b0, 0, 16'd1);
        run_txn(1'b1, 8'd2, 8'd5, 1, 8'd253, 1'b0, 0, 16'd2);
        run_txn(1'b0, 8'd255, 8'd1, 3, 8'd0, 1'b0, 0, 16'd3);
        run_txn(1'b0, 8'd5, 8'd2, 1, 8'd3, 1'b1, 4, 16'd4);

        bus.alu_done = 1'b1;
        bus.alu_s    = 8'hAA;
        @(negedge sys_clk);
        bus.alu_done = 1'b0;
        bus.alu_s    = 8'h00;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $error("FAIL spur_cmd_ready: observed %0h expected %0h", bus.cmd_ready, 1'b1);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $error("FAIL spur_rsp_valid: observed %0h expected %0h", bus.rsp_valid, 1'b0);
        end
        checks++;
        if (bus.alu_en !== 1'b0) begin
            errors++;
            $error("FAIL spur_alu_en: observed %0h expected %0h", bus.alu_en, 1'b0);
        end
        checks++;
        if (txn_count !== 16'd4) begin
            errors++;
            $error("FAIL spur_txn_count: observed %0h expected %0h", txn_count, 16'd4);
        end
        @(negedge sys_clk);
        chk("spur_cmd_ready2", bus.cmd_ready, 1'b1);
        chk("spur_rsp_data", bus.rsp_data, 8'h00);

        chk("to_cmd_ready", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_a     = 8'd9;
        bus.cmd_b     = 8'd9;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        chk("to_alu_en", bus.alu_en, 1'b1);
`ifdef ALU_REQ_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            @(negedge sys_clk);
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $error("FAIL to_rsp_valid_wait: observed %0h expected %0h", bus.rsp_valid, 1'b0);
            end
        end
        @(negedge sys_clk);
        chk("to_rsp_valid", bus.rsp_valid, 1'b1);
        chk("to_rsp_err", bus.rsp_err, 1'b1);
        chk("to_rsp_data", bus.rsp_data, 8'h00);
        chk("to_rsp_mismatch", bus.rsp_mismatch, 1'b0);
        bus.rsp_ready = 1'b1;
        @(negedge sys_clk);
        bus.rsp_ready = 1'b0;
        chk("to_txn_count", txn_count, 16'd5);
        chk("to_cmd_ready_after", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b1;
        bus.cmd_a     = 8'd9;
        bus.cmd_b     = 8'd4;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
`else
        for (int i = 1; i <= 100; i++) begin
            @(negedge sys_clk);
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $error("FAIL hold_rsp_valid: observed %0h expected %0h", bus.rsp_valid, 1'b0);
            end
        end
        chk("hold_cmd_ready", bus.cmd_ready, 1'b0);
        chk("hold_alu_a", bus.alu_a, 8'd9);
`endif

        checks++;
        if (bus.alu_a !== 8'd9) begin
            errors++;
            $error("FAIL pre_reset_alu_a: observed %0h expected %0h", bus.alu_a, 8'd9);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $error("FAIL post_reset_cmd_ready: observed %0h expected %0h", bus.cmd_ready, 1'b1);
        end
        checks++;
        if (txn_count !== 16'd0) begin
            errors++;
            $error("FAIL post_reset_txn_count: observed %0h expected %0h", txn_count, 16'd0);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $error("FAIL post_reset_rsp_valid: observed %0h expected %0h", bus.rsp_valid, 1'b0);
        end
        run_txn(1'b0, 8'd1, 8'd1, 1, 8'd2, 1'b0, 0, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
